// File: rtl/proc_io_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : proc_io_fifo                                               |
// | Description : Per-channel FIFO front-end for the processor core I/O      |
// |               port. Input channels buffer valid/ready streams towards    |
// |               the core; output channels buffer core writes towards       |
// |               downstream valid/ready sinks.                              |
// | Option      : define PROC_IO_FIFO_ERR_EN for sticky in_unf/out_ovf flags |
// |               cleared by err_clr; otherwise both flags read as zero.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module proc_io_fifo #(
  parameter int NUBITS = 16,
  parameter int NUIOIN = 2,
  parameter int NUIOOU = 2,
  parameter int FDEPTH = 4,
  localparam int AIW   = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
  localparam int AOW   = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_in,
  input  logic [AIW-1:0]           addr_in,
  output logic [NUBITS-1:0]        io_in,
  input  logic                     out_en,
  input  logic [AOW-1:0]           addr_out,
  input  logic [NUBITS-1:0]        io_out,
  input  logic [NUIOIN*NUBITS-1:0] s_data,
  input  logic [NUIOIN-1:0]        s_valid,
  output logic [NUIOIN-1:0]        s_ready,
  output logic [NUIOOU*NUBITS-1:0] m_data,
  output logic [NUIOOU-1:0]        m_valid,
  input  logic [NUIOOU-1:0]        m_ready,
  input  logic                     err_clr,
  output logic [NUIOIN-1:0]        in_unf,
  output logic [NUIOOU-1:0]        out_ovf
);

  localparam int PW = $clog2(FDEPTH);
  localparam int CW = PW + 1;

  logic [NUBITS-1:0] w_in_head [NUIOIN];
  logic [NUIOIN-1:0] w_in_pop;
  logic [NUIOIN-1:0] w_in_unf_set;
  logic [NUIOOU-1:0] w_out_ovf_set;
  logic [NUBITS-1:0] io_in_q, io_in_d;

  // ---------------- input channels: stream push, core pop ----------------
  for (genvar k = 0; k < NUIOIN; k++) begin : g_in
    logic [NUBITS-1:0] mem_q [FDEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q;
    logic              w_sel, w_push, w_pop, w_empty;

    // s_ready depends on stored occupancy only, never on this cycle's pop
    assign s_ready[k]      = (cnt_q != CW'(FDEPTH));
    assign w_empty         = (cnt_q == '0);
    assign w_sel           = req_in && (addr_in == AIW'(k));
    assign w_push          = s_valid[k] && s_ready[k];
    assign w_pop           = w_sel && !w_empty;
    assign w_in_pop[k]     = w_pop;
    assign w_in_unf_set[k] = w_sel && w_empty;
    assign w_in_head[k]    = mem_q[rd_ptr_q];

    // storage is deliberately not reset; pointers define what is valid
    always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q] <= s_data[k*NUBITS +: NUBITS];
    end

    // pointer and occupancy update; reset drops in-flight handshakes
    always_ff @(posedge clk) begin
      if (!rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (w_push && !w_pop)      cnt_q <= cnt_q + 1'b1;
        else if (!w_push && w_pop) cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // core read data: head of the popped channel, otherwise hold
  always_comb begin
    io_in_d = io_in_q;
    for (int k = 0; k < NUIOIN; k++) begin
      if (w_in_pop[k]) io_in_d = w_in_head[k];
    end
  end

  // registered core read data (one-cycle latency like data memory)
  always_ff @(posedge clk) begin
    if (!rst) io_in_q <= '0;
    else      io_in_q <= io_in_d;
  end

  assign io_in = io_in_q;

  // ---------------- output channels: core push, stream pop ----------------
  for (genvar j = 0; j < NUIOOU; j++) begin : g_out
    logic [NUBITS-1:0] mem_q [FDEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     cnt_q;
    logic              w_sel, w_push, w_pop, w_full;

    assign m_valid[j] = (cnt_q != '0);
    assign w_full     = (cnt_q == CW'(FDEPTH));
    assign w_sel      = out_en && (addr_out == AOW'(j));
    assign w_pop      = m_valid[j] && m_ready[j];
    // a full channel still accepts when its head leaves in the same cycle
    assign w_push           = w_sel && (!w_full || w_pop);
    assign w_out_ovf_set[j] = w_sel && w_full && !w_pop;
    // gate with valid so an empty channel presents zero, not stale storage
    assign m_data[j*NUBITS +: NUBITS] = m_valid[j] ? mem_q[rd_ptr_q] : '0;

    // storage is deliberately not reset; pointers define what is valid
    always_ff @(posedge clk) begin
      if (w_push) mem_q[wr_ptr_q] <= io_out;
    end

    // pointer and occupancy update; reset drops in-flight handshakes
    always_ff @(posedge clk) begin
      if (!rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        if (w_push && !w_pop)      cnt_q <= cnt_q + 1'b1;
        else if (!w_push && w_pop) cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // ---------------- error flags ----------------
`ifdef PROC_IO_FIFO_ERR_EN
  logic [NUIOIN-1:0] in_unf_q, in_unf_d;
  logic [NUIOOU-1:0] out_ovf_q, out_ovf_d;

  // sticky flags: a new event in the clear cycle keeps the flag set
  always_comb begin
    in_unf_d  = (in_unf_q  & {NUIOIN{~err_clr}}) | w_in_unf_set;
    out_ovf_d = (out_ovf_q & {NUIOOU{~err_clr}}) | w_out_ovf_set;
  end

  // flag registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_unf_q  <= '0;
      out_ovf_q <= '0;
    end else begin
      in_unf_q  <= in_unf_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign in_unf  = in_unf_q;
  assign out_ovf = out_ovf_q;
`else
  logic unused_err;
  assign unused_err = ^{err_clr, w_in_unf_set, w_out_ovf_set};
  assign in_unf     = '0;
  assign out_ovf    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_proc_io_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_proc_io_fifo                                            |
// | Description : Directed self-checking bench for proc_io_fifo (defaults:   |
// |               NUBITS=16, NUIOIN=2, NUIOOU=2, FDEPTH=4). Flag             |
// |               expectations follow PROC_IO_FIFO_ERR_EN.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_proc_io_fifo;

`ifdef PROC_IO_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_in;
  logic [0:0]  addr_in;
  logic [15:0] io_in;
  logic        out_en;
  logic [0:0]  addr_out;
  logic [15:0] io_out;
  logic [31:0] s_data;
  logic [1:0]  s_valid;
  logic [1:0]  s_ready;
  logic [31:0] m_data;
  logic [1:0]  m_valid;
  logic [1:0]  m_ready;
  logic        err_clr;
  logic [1:0]  in_unf;
  logic [1:0]  out_ovf;

  int n_vec = 0;
  int n_err = 0;

  proc_io_fifo dut (
    .clk(clk), .rst(rst),
    .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
    .out_en(out_en), .addr_out(addr_out), .io_out(io_out),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .err_clr(err_clr), .in_unf(in_unf), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge; outputs are sampled and inputs changed 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_in = 0; addr_in = 0; out_en = 0; addr_out = 0; io_out = 0;
    s_data = 0; s_valid = 0; m_ready = 0; err_clr = 0;
  endtask

  initial begin
    logic [15:0] v;
    // reset with random stimulus
    rst = 0;
    for (int c = 0; c < 2; c++) begin
      req_in = 1'($urandom); addr_in = 1'($urandom); out_en = 1'($urandom);
      addr_out = 1'($urandom); io_out = 16'($urandom); s_data = $urandom;
      s_valid = 2'($urandom); m_ready = 2'($urandom); err_clr = 1'($urandom);
      step();
    end
    check_eq("rst_io_in", io_in, 0);
    check_eq("rst_s_ready", s_ready, 2'b11);
    check_eq("rst_m_valid", m_valid, 2'b00);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_in_unf", in_unf, 0);
    check_eq("rst_out_ovf", out_ovf, 0);
    rst = 1;
    idle_inputs();

    // input fill on channel 1; fifth word refused
    for (int i = 0; i < 5; i++) begin
      s_valid = 2'b10;
      s_data[31:16] = 16'(17 * (i + 1));
      check_eq("fill_s_ready1", s_ready[1], (i < 4) ? 1 : 0);
      step();
    end
    s_valid = 0;
    check_eq("full_s_ready1", s_ready[1], 0);

    // drain channel 1 through the core port
    req_in = 1; addr_in = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i == 3) req_in = 0;
      check_eq("drain_io_in", io_in, 16'(17 * (i + 1)));
    end
    check_eq("drained_s_ready1", s_ready[1], 1);

    // underflow on empty channel 0
    req_in = 1; addr_in = 0;
    step();
    req_in = 0;
    check_eq("unf_io_hold", io_in, 16'h0044);
    check_eq("unf_flag", in_unf, ERR_EN ? 2'b01 : 2'b00);
    err_clr = 1;
    step();
    err_clr = 0;
    check_eq("unf_clr", in_unf, 0);
    // set wins over clear
    req_in = 1; addr_in = 0; err_clr = 1;
    step();
    req_in = 0; err_clr = 0;
    check_eq("unf_set_wins", in_unf, ERR_EN ? 2'b01 : 2'b00);
    err_clr = 1;
    step();
    err_clr = 0;

    // output backpressure on channel 0
    m_ready = 0; out_en = 1; addr_out = 0;
    for (int i = 0; i < 5; i++) begin
      io_out = 16'(16'h0A01 + i);
      step();
      if (i == 0) begin
        check_eq("bp_m_valid0", m_valid[0], 1);
        check_eq("bp_m_data0", m_data[15:0], 16'h0A01);
      end
      if (i == 3) check_eq("bp_no_ovf_yet", out_ovf, 0);
    end
    out_en = 0;
    check_eq("bp_ovf", out_ovf, ERR_EN ? 2'b01 : 2'b00);
    m_ready = 2'b01;
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_drain_valid", m_valid[0], 1);
      check_eq("bp_drain_data", m_data[15:0], 16'(16'h0A01 + i));
      step();
    end
    check_eq("bp_empty_valid", m_valid[0], 0);
    check_eq("bp_empty_data", m_data[15:0], 0);
    m_ready = 0; err_clr = 1;
    step();
    err_clr = 0;

    // full output channel with simultaneous pop
    out_en = 1; addr_out = 1;
    for (int i = 0; i < 4; i++) begin
      io_out = 16'(16'h0B01 + i);
      step();
    end
    check_eq("fp_head", m_data[31:16], 16'h0B01);
    io_out = 16'h0B05; m_ready = 2'b10;
    step();
    out_en = 0; m_ready = 0;
    check_eq("fp_no_ovf", out_ovf, 0);
    m_ready = 2'b10;
    for (int i = 0; i < 4; i++) begin
      check_eq("fp_drain", m_data[31:16], 16'(16'h0B02 + i));
      step();
    end
    check_eq("fp_empty", m_valid[1], 0);
    m_ready = 0;

    // input wrap-around: push and read overlapped, 13 words per channel
    for (int ch = 0; ch < 2; ch++) begin
      addr_in = 1'(ch);
      for (int i = 0; i < 14; i++) begin
        s_valid = (i < 13) ? 2'(1 << ch) : 2'b00;
        s_data[ch*16 +: 16] = 16'(16'h1000 * (ch + 1) + i);
        req_in = (i > 0);
        step();
        if (i > 0) check_eq("wrap_in", io_in, 16'(16'h1000 * (ch + 1) + i - 1));
      end
      req_in = 0; s_valid = 0;
    end
    check_eq("wrap_in_empty", s_ready, 2'b11);

    // output wrap-around: continuous write and pop on channel 0
    m_ready = 2'b01; out_en = 1; addr_out = 0;
    for (int i = 0; i < 13; i++) begin
      v = 16'(16'h5000 + i);
      io_out = v;
      step();
      check_eq("wrap_out", m_data[15:0], v);
    end
    out_en = 0;
    step();
    check_eq("wrap_out_empty", m_valid, 0);
    m_ready = 0;

    // mid-operation reset with partially filled channels
    s_valid = 2'b11; s_data = 32'h2222_1111;
    step();
    s_data = 32'h2223_1112;
    step();
    s_valid = 0; out_en = 1; addr_out = 0; io_out = 16'h3333;
    step();
    out_en = 0;
    check_eq("pre_rst_m_valid", m_valid, 2'b01);
    rst = 0; s_valid = 2'b11; out_en = 1; m_ready = 2'b11; req_in = 1; addr_in = 0;
    step();
    rst = 1;
    idle_inputs();
    check_eq("mrst_s_ready", s_ready, 2'b11);
    check_eq("mrst_m_valid", m_valid, 0);
    check_eq("mrst_m_data", m_data, 0);
    check_eq("mrst_io_in", io_in, 0);
    check_eq("mrst_flags", {in_unf, out_ovf}, 0);
    s_valid = 2'b01; s_data = 32'h0000_7777;
    step();
    s_valid = 0; req_in = 1; addr_in = 0;
    step();
    check_eq("mrst_read", io_in, 16'h7777);
    addr_in = 1;
    step();
    req_in = 0;
    check_eq("mrst_unf_hold", io_in, 16'h7777);
    check_eq("mrst_unf_flag", in_unf, ERR_EN ? 2'b10 : 2'b00);
    out_en = 1; addr_out = 1; io_out = 16'h6666;
    step();
    out_en = 0;
    check_eq("mrst_out_valid", m_valid, 2'b10);
    check_eq("mrst_out_data", m_data[31:16], 16'h6666);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
